// File: rtl/ym_pkg.sv
// Shared types and constants for the YM2149 bus responder: bus modes,
// named register indices and the per-register implemented-bit masks.
package ym_pkg;

    typedef enum logic [1:0] {
        MODE_INACTIVE = 2'b00,
        MODE_READ     = 2'b01,
        MODE_WRITE    = 2'b10,
        MODE_LATCH    = 2'b11
    } ym_mode_e;

    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;

    // Bits a real PSG implements per register; unimplemented bits read as 0.
    localparam logic [7:0] MASK [16] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'hFF,
        8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF
    };

    // WRITE and LATCH capture data and commit on exit.
    function automatic logic is_hold_mode(input ym_mode_e m);
        return (m == MODE_WRITE) || (m == MODE_LATCH);
    endfunction

endpackage

// File: rtl/ym_bus_sync.sv
// Synchronises the asynchronous PSG bus pins and qualifies the bus mode:
// the mode only moves once two consecutive synchronised samples agree.
module ym_bus_sync
    import ym_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       bdir_i,
    input  logic       bc1_i,
    input  logic [7:0] da_i,
    output ym_mode_e   q_o,
    output ym_mode_e   q_next_o,
    output ym_mode_e   mode_cmp_o,
    output logic [7:0] data_cmp_o
);

    localparam int W = 11;

    logic [SYNC_STAGES*W-1:0] sync_q;
    logic [W-1:0]             cmp_q;
    logic [W-1:0]             sync_tail;
    ym_mode_e                 mode_sync;
    ym_mode_e                 mode_cmp;
    ym_mode_e                 q_q;
    ym_mode_e                 q_d;

    // A deselected chip sees the bus as idle regardless of bdir/bc1.
    function automatic ym_mode_e decode(input logic [W-1:0] v);
        return v[10] ? ym_mode_e'(v[9:8]) : MODE_INACTIVE;
    endfunction

    assign sync_tail = sync_q[SYNC_STAGES*W-1 -: W];
    assign mode_sync = decode(sync_tail);
    assign mode_cmp  = decode(cmp_q);

    always_comb begin
        q_d = q_q;
        if (mode_sync == mode_cmp) begin
            q_d = mode_sync;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cmp_q  <= '0;
            q_q    <= MODE_INACTIVE;
        end else begin
            sync_q <= {sync_q[(SYNC_STAGES-1)*W-1:0], cs_i, bdir_i, bc1_i, da_i};
            cmp_q  <= sync_tail;
            q_q    <= q_d;
        end
    end

    assign q_o        = q_q;
    assign q_next_o   = q_d;
    assign mode_cmp_o = mode_cmp;
    assign data_cmp_o = cmp_q[7:0];

endmodule

// File: rtl/ym2149_bus_responder.sv
// Chip-side BDIR/BC1/DA responder for one PSG: address latch, masked
// register file, bus read-back, generator read port and envelope restart.
module ym2149_bus_responder
    import ym_pkg::*;
#(
    parameter int CHIP_ID     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] da_in,
    output logic [7:0] da_out,
    output logic       da_oe,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       env_restart,
    output logic [3:0] addr_q
);

    localparam logic [3:0] CHIP_NIB = 4'(CHIP_ID);

    ym_mode_e   q;
    ym_mode_e   q_next;
    ym_mode_e   mode_cmp;
    logic [7:0] data_cmp;

    logic [7:0] dh_q, dh_d;
    logic [3:0] addr_d;
    logic       sel_valid_q, sel_valid_d;
    logic       commit_wr;
    logic [7:0] regs_q [16];
    logic [7:0] rd_data_q;
    logic       env_q;

    ym_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (cpu_clock),
        .rst_i      (reset),
        .cs_i       (cs),
        .bdir_i     (bdir),
        .bc1_i      (bc1),
        .da_i       (da_in),
        .q_o        (q),
        .q_next_o   (q_next),
        .mode_cmp_o (mode_cmp),
        .data_cmp_o (data_cmp)
    );

    // Commits act on the value held in dh, so a mode change never picks up
    // data that arrived together with the new mode.
    always_comb begin
        dh_d        = dh_q;
        addr_d      = addr_q;
        sel_valid_d = sel_valid_q;
        commit_wr   = 1'b0;
        if (mode_cmp == q && is_hold_mode(q)) begin
            dh_d = data_cmp;
        end
        if (q == MODE_LATCH && q_next != MODE_LATCH) begin
            if (dh_q[7:4] == 4'h0) begin
                addr_d      = dh_q[3:0];
                sel_valid_d = 1'b1;
            end else begin
                sel_valid_d = 1'b0;
            end
        end
        if (q == MODE_WRITE && q_next != MODE_WRITE && sel_valid_q) begin
            commit_wr = 1'b1;
        end
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            dh_q        <= 8'h00;
            addr_q      <= 4'h0;
            sel_valid_q <= 1'b1;
            rd_data_q   <= 8'h00;
            env_q       <= 1'b0;
        end else begin
            dh_q        <= dh_d;
            addr_q      <= addr_d;
            sel_valid_q <= sel_valid_d;
            rd_data_q   <= regs_q[rd_addr];
            env_q       <= commit_wr && (addr_q == R_ENV_SHAPE);
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        always_ff @(posedge cpu_clock or posedge reset) begin
            if (reset) begin
                regs_q[gi] <= 8'h00;
            end else if (commit_wr && addr_q == 4'(gi)) begin
                regs_q[gi] <= dh_q & MASK[gi];
            end
        end
    end

    assign da_oe = (q == MODE_READ);

    always_comb begin
        da_out = 8'h00;
        if (q == MODE_READ) begin
            da_out = sel_valid_q ? regs_q[addr_q] : {CHIP_NIB, 4'hF};
        end
    end

    assign rd_data     = rd_data_q;
    assign env_restart = env_q;

endmodule
